// File: rtl/pwm_audio_pkg.sv
// pwm_audio_pkg
// Shared definitions for the multi-channel PWM / sigma-delta audio modulator:
// the 2-bit modulation mode type, its encodings and a small mode decode helper.
package pwm_audio_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_MUTE = 2'd0;
    localparam mode_t MODE_PWM  = 2'd1;
    localparam mode_t MODE_SDM1 = 2'd2;
    localparam mode_t MODE_RSVD = 2'd3;

    // The reserved encoding behaves exactly like mute.
    function automatic logic mode_is_mute(input mode_t m);
        return (m == MODE_MUTE) || (m == MODE_RSVD);
    endfunction

endpackage

// File: rtl/pwm_audio_chan.sv
// pwm_audio_chan
// One modulator channel. Holds the active sample, the sigma-delta accumulator
// and the registered 1-bit output.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   ena          clock enable; state advances only when high
//   load         boundary with a pending sample: take 'sample' as active value
//   sample       shadow-buffer slice for this channel
//   mode_q       mode applied for the current frame
//   mode_change  boundary where the applied mode changes: clear accumulator
//   cnt          shared frame counter
//   dac_out      registered modulator output
module pwm_audio_chan
    import pwm_audio_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] sample,
    input  mode_t            mode_q,
    input  logic             mode_change,
    input  logic [WIDTH-1:0] cnt,
    output logic             dac_out
);

    logic [WIDTH-1:0] active_r;
    logic [WIDTH:0]   acc_r;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   acc_mode_s;
    logic [WIDTH:0]   acc_nxt_s;
    logic             dac_nxt_s;

    // Next output and accumulator value for the applied mode.
    always_comb begin
        sum_s      = {1'b0, acc_r[WIDTH-1:0]} + {1'b0, active_r};
        acc_mode_s = acc_r;
        dac_nxt_s  = dac_out;
        case (mode_q)
            MODE_PWM: begin
                dac_nxt_s  = (active_r > cnt);
                acc_mode_s = acc_r;
            end
            MODE_SDM1: begin
                dac_nxt_s  = sum_s[WIDTH];
                acc_mode_s = sum_s;
            end
            default: begin
                dac_nxt_s  = 1'b0;
                acc_mode_s = '0;
            end
        endcase
        // A mode switch at the boundary restarts the accumulator from zero.
        acc_nxt_s = mode_change ? {(WIDTH+1){1'b0}} : acc_mode_s;
    end

    // Channel state: active sample, accumulator and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_r <= '0;
            acc_r    <= '0;
            dac_out  <= 1'b0;
        end else if (ena) begin
            if (load) begin
                active_r <= sample;
            end
            acc_r   <= acc_nxt_s;
            dac_out <= dac_nxt_s;
        end
    end

endmodule

// File: rtl/pwm_audio_mc.sv
// pwm_audio_mc
// Multi-channel audio DAC modulator (PWM or first-order sigma-delta), one
// 1-bit output per channel, all channels sharing one frame counter.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   ena              clock enable for modulation
//   mode             requested mode, taken at frame boundaries
//   s_valid/s_ready  sample-frame handshake into the shadow buffer
//   s_data           CHANNELS unsigned samples, channel k at [k*WIDTH +: WIDTH]
//   clear_underrun   clears the sticky underrun flag
//   dac_out          registered modulator outputs
//   frame_start      one-cycle pulse in the first cycle of each frame
//   underrun         sticky: a frame began with no new sample pending
module pwm_audio_mc
    import pwm_audio_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic [1:0]                mode,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [CHANNELS*WIDTH-1:0] s_data,
    input  logic                      clear_underrun,
    output logic [CHANNELS-1:0]       dac_out,
    output logic                      frame_start,
    output logic                      underrun
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]          cnt_r;
    logic [CHANNELS*WIDTH-1:0] shadow_r;
    logic                      shadow_full_r;
    mode_t                     mode_q_r;

    logic boundary_s;
    logic accept_s;
    logic load_s;
    logic mode_change_s;

    assign boundary_s    = ena && (cnt_r == CNT_MAX);
    assign s_ready       = !shadow_full_r;
    assign accept_s      = s_valid && !shadow_full_r;
    assign load_s        = boundary_s && shadow_full_r;
    assign mode_change_s = boundary_s && (mode != mode_q_r);

    // Shared frame counter, wraps naturally at 2^WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (ena) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Shadow buffer: filled by the handshake, drained at a boundary. Accept and
    // drain are exclusive because s_ready is low whenever a drain can happen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_r      <= '0;
            shadow_full_r <= 1'b0;
        end else if (accept_s) begin
            shadow_r      <= s_data;
            shadow_full_r <= 1'b1;
        end else if (load_s) begin
            shadow_full_r <= 1'b0;
        end
    end

    // Sticky underrun; a new underrun wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (boundary_s && !shadow_full_r) begin
            underrun <= 1'b1;
        end else if (clear_underrun) begin
            underrun <= 1'b0;
        end
    end

    // Applied mode and frame-start pulse, both updated at the boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q_r    <= MODE_MUTE;
            frame_start <= 1'b0;
        end else begin
            frame_start <= boundary_s;
            if (boundary_s) begin
                mode_q_r <= mode;
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        pwm_audio_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .ena        (ena),
            .load       (load_s),
            .sample     (shadow_r[k*WIDTH +: WIDTH]),
            .mode_q     (mode_q_r),
            .mode_change(mode_change_s),
            .cnt        (cnt_r),
            .dac_out    (dac_out[k])
        );
    end

endmodule

// File: tb/tb_pwm_audio_mc.sv
// tb_pwm_audio_mc
// Directed bench for pwm_audio_mc (WIDTH=8, CHANNELS=2). The stimulus pushes
// the expected per-frame result (ones per channel over the frame's ena cycles,
// underrun flag at frame start, frame length in clocks) into a queue; a
// monitor accumulates the DUT outputs and compares on every frame_start.
module tb_pwm_audio_mc;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 2;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      ena = 1'b0;
    logic [1:0]                mode = 2'd0;
    logic                      s_valid = 1'b0;
    logic                      s_ready;
    logic [CHANNELS*WIDTH-1:0] s_data = '0;
    logic                      clear_underrun = 1'b0;
    logic [CHANNELS-1:0]       dac_out;
    logic                      frame_start;
    logic                      underrun;

    pwm_audio_mc #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .mode          (mode),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .clear_underrun(clear_underrun),
        .dac_out       (dac_out),
        .frame_start   (frame_start),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int o0;
        int o1;
        int ur;
        int len;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cnt_m = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic push(input int o0, input int o1, input int ur, input int len);
        exp_t e;
        e.o0 = o0; e.o1 = o1; e.ur = ur; e.len = len;
        q.push_back(e);
    endtask

    // One clock; inputs are changed 1 time unit after the edge.
    task automatic tick();
        bit e;
        e = ena && !rst;
        @(posedge clk);
        #1;
        if (e) cnt_m = (cnt_m + 1) % 256;
    endtask

    task automatic run_to(input int t);
        int guard;
        guard = 0;
        while (cnt_m != t && guard < 1024) begin
            tick();
            guard++;
        end
        if (cnt_m != t) begin
            n_err++;
            $display("FAIL run_to: counter %0d never reached %0d", cnt_m, t);
        end
    endtask

    task automatic next_frame();
        tick();
        run_to(0);
    endtask

    // Monitor: per-frame accumulation, compared on each frame_start.
    bit rst_p = 1'b1;
    bit ena_p = 1'b0;
    int ones0 = 0;
    int ones1 = 0;
    int flen  = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            ones0 = 0; ones1 = 0; flen = 0;
            rst_p = 1'b1;
        end else begin
            if (!rst_p) begin
                flen++;
                if (ena_p) begin
                    ones0 += int'(dac_out[0]);
                    ones1 += int'(dac_out[1]);
                end
            end
            if (frame_start === 1'b1) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL frame_unexpected: frame_start with no expected frame queued");
                end else begin
                    e = q.pop_front();
                    chk("frame_ones_ch0", ones0, e.o0);
                    chk("frame_ones_ch1", ones1, e.o1);
                    chk("frame_underrun", {31'd0, underrun}, e.ur);
                    chk("frame_len", flen, e.len);
                end
                ones0 = 0; ones1 = 0; flen = 0;
            end
            rst_p = 1'b0;
        end
        ena_p = ena;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] prev;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dac", dac_out, 2'd0);
        chk("rst_ready", s_ready, 1'b1);
        chk("rst_fs", frame_start, 1'b0);
        chk("rst_ur", underrun, 1'b0);

        // F1 mute (mode applies at first boundary), F2/F3 PWM 64 on ch0.
        rst = 1'b0; ena = 1'b1; mode = 2'd1;
        s_valid = 1'b1; s_data = {8'd0, 8'd64};
        tick();
        s_valid = 1'b0;
        chk("ready_after_acc", s_ready, 1'b0);
        push(0, 0, 0, 256);
        push(64, 0, 1, 256);
        run_to(0);
        next_frame();

        // F3: clear underrun, send next frame, request SDM mid-frame.
        push(64, 0, 0, 256);
        run_to(10);
        clear_underrun = 1'b1;
        tick();
        clear_underrun = 1'b0;
        run_to(20);
        s_valid = 1'b1; s_data = {8'd255, 8'd128};
        tick();
        s_valid = 1'b0;
        run_to(100);
        mode = 2'd2;
        run_to(0);

        // F4: SDM, ch0=128 alternates, ch1=255; no new sample -> underrun.
        push(128, 255, 1, 256);
        for (int j = 1; j <= 8; j++) begin
            tick();
            chk("sdm_alt", dac_out[0], (cnt_m % 2 == 0) ? 1'b1 : 1'b0);
        end
        run_to(50);
        mode = 2'd3;
        run_to(0);

        // F5: reserved mode mutes; clear flag; hold s_valid from here on.
        push(0, 0, 0, 256);
        run_to(5);
        clear_underrun = 1'b1;
        tick();
        clear_underrun = 1'b0;
        run_to(10);
        s_valid = 1'b1; s_data = {8'd32, 8'd200}; mode = 2'd1;
        run_to(255);
        chk("ready_full", s_ready, 1'b0);
        push(200, 32, 0, 256);
        tick();
        chk("ready_bnd", s_ready, 1'b1);
        tick();
        chk("ready_reacc", s_ready, 1'b0);
        run_to(0);

        // F7: steady streaming, one frame accepted per frame.
        push(200, 32, 0, 256);
        next_frame();

        // F8: ena every other cycle, frame 512 clocks; SDM requested for F9.
        push(200, 32, 0, 512);
        mode = 2'd2;
        for (int i = 0; i < 512; i++) begin
            ena = (i % 2 == 1);
            prev = dac_out;
            tick();
            if (i < 40 && (i % 2 == 0)) chk("hold_ena0", dac_out, prev);
        end
        ena = 1'b1;

        // F9: SDM, asynchronous reset at cnt 37.
        run_to(37);
        rst = 1'b1;
        #1;
        chk("arst_dac", dac_out, 2'd0);
        chk("arst_ready", s_ready, 1'b1);
        chk("arst_fs", frame_start, 1'b0);
        chk("arst_ur", underrun, 1'b0);
        cnt_m = 0;
        tick();
        rst = 1'b0; s_valid = 1'b0; mode = 2'd0;
        chk("rel_fs", frame_start, 1'b0);

        // F10: mute, empty shadow; clear coincides with the underrun set.
        push(0, 0, 1, 256);
        run_to(255);
        clear_underrun = 1'b1;
        tick();
        clear_underrun = 1'b0;
        repeat (4) tick();
        chk("ur_set_wins", underrun, 1'b1);
        chk("frames_pending", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
